mux_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4_1_rr_arbiter
//
// PURPOSE
//  Shares one 4:1 mux datapath among four requesters using a round-robin arbiter.
//  Each requester has a valid/ready handshake. The winner's data is captured
//  into a one-entry output register, together with the mux select that chose it.
//  Downstream also uses a valid/ready handshake.
//  Sits between the requester channels and the consumer of the shared mux output.
//
// PARAMETERS
//  W   4   data width of each requester channel and of out_data
//
// PORTS
//  clk        in   1    clock; all state updates on the rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   4    bit i: requester i presents valid data on d<i>
//  d0..d3     in   W    requester data channels 0..3
//  in_ready   out  4    bit i: requester i's data is taken this cycle (one-hot or zero)
//  out_valid  out  1    output register holds a word
//  out_data   out  W    registered mux output
//  out_sel    out  2    index of the requester that supplied out_data
//  out_ready  in   1    downstream accepts out_data this cycle
//
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
//    in_ready is combinational and is 0 while rst=1.
//  - Handshakes:
//    - Input transfer on requester i: in_valid[i] && in_ready[i] at a rising edge.
//    - Output transfer: out_valid && out_ready at a rising edge.
//  - can_load = !out_valid || out_ready.
//    A drain and a load in the same cycle is allowed, so one word per cycle is sustained.
//  - Arbitration (combinational):
//    - When can_load, grant the first i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//    - in_ready = onehot(grant); in_ready=0 if no request or !can_load.
//    - in_ready must not depend on out_data.
//  - On an input transfer from i, at the next edge:
//    - out_data <= d<i>, out_sel <= i, out_valid <= 1
//    - ptr <= (i+1) mod 4 (2-bit wrap; 3 -> 0)
//  - On an output transfer with no new grant: out_valid <= 0. out_data and out_sel hold their values.
//  - With no transfer at all, every register holds.
//  - Backpressure: while out_valid && !out_ready:
//    - in_ready = 0; out_data, out_sel and ptr are stable.
//    - Requesters must hold in_valid and data; the arbiter does not store losers.
//  - Latency: input transfer to out_valid is 1 cycle.
//    With out_ready tied high, each active requester is served at least once every 4 cycles.
//  - ptr advances only on a grant; idle cycles do not rotate it.
//  - Reset mid-operation: the word in the output register is dropped and ptr returns to 0.
//    A transfer in the reset cycle is not performed.
//  - The arbiter is fair: no requester waits more than 3 grants while it holds in_valid.
//
// TESTING
//  1. rst=1 for 2 cycles, then in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
//  2. out_ready=1; in_valid=4'b1111; d0..d3=1,2,3,4; run 8 cycles
//     -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4, one word per cycle.
//  3. Grant 2 (ptr=3), then in_valid=4'b0101 -> next grant goes to 0 (ptr wraps), then to 2.
//  4. out_valid=1, out_ready=0 for 3 cycles, in_valid=4'b0010
//     -> in_ready=0 and out_data stable throughout.
//     Then out_ready=1 -> in_ready=4'b0010 the same cycle; next cycle out_sel=1.
//  5. Single requester 3, continuous, d3 increments 0..15 with out_ready=1
//     -> 16 consecutive words 0..15, out_sel=3, no bubbles.
//  6. rst asserted while out_valid=1 and in_valid=4'b1000
//     -> next cycle out_valid=0 and ptr=0.
//     After release with in_valid=4'b1001, requester 0 wins first.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four valid/ready requesters,
// feeding a one-entry registered output stage with its own valid/ready handshake.
module mux_4_1_rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  logic [1:0]   ptr;
  logic [3:0]   gnt;
  logic [1:0]   gsel;
  logic         found;
  logic [1:0]   idx;
  logic         can_load;
  logic [W-1:0] mux_data;

  assign can_load = !out_valid || out_ready;

  // Scan from ptr upward (mod 4); the first requester seen wins.
  always_comb begin
    gnt   = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        gnt[idx] = 1'b1;
        gsel     = idx;
        found    = 1'b1;
      end
    end
  end

  assign in_ready = (rst || !can_load) ? '0 : gnt;

  always_comb begin
    mux_data = '0;
    case (gsel)
      2'd0: mux_data = d0;
      2'd1: mux_data = d1;
      2'd2: mux_data = d2;
      2'd3: mux_data = d3;
      default: mux_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (|in_ready) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= gsel;
      ptr       <= gsel + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed-vector bench for mux_4_1_rr_arbiter: stimulus pushes hand-computed
// words into a scoreboard queue; a monitor pops them on each output transfer.
module tb_mux_4_1_rr_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;
  logic [W+1:0] sb[$];  // {data, sel}
  logic done = 1'b0;

  mux_4_1_rr_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int data, input int sel);
    sb.push_back({W'(data), 2'(sel)});
  endtask

  // Monitor: an output transfer is seen mid-cycle, inputs being stable then.
  always @(negedge clk) begin
    if (!done && !rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        logic [W+1:0] e;
        e = sb.pop_front();
        chk("sb_data", int'(out_data), int'(e[W+1:2]));
        chk("sb_sel", int'(out_sel), int'(e[1:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // 1. reset
    cyc();
    in_valid = 4'b1111; #1;
    chk("rst_in_ready", int'(in_ready), 0);
    in_valid = '0;
    cyc();
    rst = 1'b0; #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_in_ready_idle", int'(in_ready), 0);

    // 2. all requesting, rotation 0,1,2,3,...
    out_ready = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_in_ready", int'(in_ready), 1 << (i % 4));
      if (i > 0) chk("rr_no_bubble", int'(out_valid), 1);
      expect_word((i % 4) + 1, i % 4);
      cyc();
    end
    in_valid = '0;
    cyc();

    // 3. ptr wrap: grant 2 then 0101 -> 0 then 2
    in_valid = 4'b0100; #1;
    chk("wrap_g2", int'(in_ready), 4'b0100);
    expect_word(3, 2);
    cyc();
    in_valid = 4'b0101; #1;
    chk("wrap_g0", int'(in_ready), 4'b0001);
    expect_word(1, 0);
    cyc(); #1;
    chk("wrap_g2b", int'(in_ready), 4'b0100);
    expect_word(3, 2);
    cyc();

    // 4. backpressure
    in_valid = 4'b1000; #1;
    chk("bp_g3", int'(in_ready), 4'b1000);
    expect_word(4, 3);
    cyc();
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_data", int'(out_data), 4);
      chk("bp_out_sel", int'(out_sel), 3);
      cyc();
    end
    out_ready = 1'b1; #1;
    chk("bp_release", int'(in_ready), 4'b0010);
    expect_word(2, 1);
    cyc();
    in_valid = '0; #1;
    chk("bp_next_sel", int'(out_sel), 1);
    cyc();

    // 5. single requester 3 streaming 0..15
    in_valid = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      d3 = 4'(k); #1;
      chk("stream_in_ready", int'(in_ready), 4'b1000);
      if (k > 0) chk("stream_no_bubble", int'(out_valid), 1);
      expect_word(k, 3);
      cyc();
    end
    in_valid = '0;
    cyc();

    // 6. reset mid-operation: load requester 2 (ptr -> 3) and hold it
    out_ready = 1'b0; in_valid = 4'b0100; d2 = 4'd3; #1;
    chk("pre_rst_grant", int'(in_ready), 4'b0100);
    cyc();
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_data", int'(out_data), 3);
    rst = 1'b1; in_valid = 4'b1000; #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    cyc();
    rst = 1'b0; #1;
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_data", int'(out_data), 0);
    in_valid = 4'b1001; out_ready = 1'b1; d0 = 4'd5; #1;
    chk("post_rst_g0", int'(in_ready), 4'b0001);
    expect_word(5, 0);
    cyc();
    in_valid = '0;
    cyc();
    cyc();

    chk("sb_empty", sb.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
